// File: rtl/ysyx_22051013_axi_arbiter_if.sv
// Bus bundle between the icache/dcache requesters, the arbiter and the downstream AXI port.
// master = arbiter side, slave = requesters plus downstream responder.
interface ysyx_22051013_axi_arbiter_if;
    logic        i_re;
    logic [63:0] i_addr;
    logic        i_valid;
    logic [63:0] i_rdata;
    logic        d_re;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_mask;
    logic        d_valid;
    logic [63:0] d_rdata;
    logic        m_re;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_mask;
    logic        m_valid;
    logic [63:0] m_rdata;
    logic [1:0]  owner;
    logic        timeout_err;

    modport master (
        input  i_re, i_addr, d_re, d_we, d_addr, d_wdata, d_mask, m_valid, m_rdata,
        output i_valid, i_rdata, d_valid, d_rdata, m_re, m_we, m_addr, m_wdata, m_mask,
               owner, timeout_err
    );

    modport slave (
        output i_re, i_addr, d_re, d_we, d_addr, d_wdata, d_mask, m_valid, m_rdata,
        input  i_valid, i_rdata, d_valid, d_rdata, m_re, m_we, m_addr, m_wdata, m_mask,
               owner, timeout_err
    );
endinterface

// File: rtl/ysyx_22051013_axi_arbiter.sv
// Two-requester (icache / dcache-side) arbiter onto one downstream AXI port.
// Round-robin on ties, one transaction in flight, forced completion after TIMEOUT busy cycles.
module ysyx_22051013_axi_arbiter #(
    parameter int TIMEOUT = 255
) (
    input logic                          clk,
    input logic                          rst_n,
    ysyx_22051013_axi_arbiter_if.master  bus
);
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_t;

    state_t        state;
    logic          last_d;
    logic [CW-1:0] cnt;
    logic          req_i, req_d, pick_d, cnt_last;

    always_comb begin
        req_i    = bus.i_re;
        req_d    = bus.d_re | bus.d_we;
        // On a tie the requester that did not win last time goes first.
        pick_d   = req_d & (~req_i | ~last_d);
        cnt_last = (cnt == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            last_d          <= 1'b0;
            cnt             <= '0;
            bus.i_valid     <= 1'b0;
            bus.i_rdata     <= '0;
            bus.d_valid     <= 1'b0;
            bus.d_rdata     <= '0;
            bus.m_re        <= 1'b0;
            bus.m_we        <= 1'b0;
            bus.m_addr      <= '0;
            bus.m_wdata     <= '0;
            bus.m_mask      <= '0;
            bus.owner       <= 2'b00;
            bus.timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pick_d) begin
                        state       <= D_BUSY;
                        last_d      <= 1'b1;
                        bus.owner   <= 2'b10;
                        bus.m_we    <= bus.d_we;
                        bus.m_re    <= ~bus.d_we;
                        bus.m_addr  <= bus.d_addr;
                        bus.m_wdata <= bus.d_wdata;
                        bus.m_mask  <= bus.d_mask;
                    end else if (req_i) begin
                        state       <= I_BUSY;
                        last_d      <= 1'b0;
                        bus.owner   <= 2'b01;
                        bus.m_we    <= 1'b0;
                        bus.m_re    <= 1'b1;
                        bus.m_addr  <= bus.i_addr;
                        bus.m_wdata <= '0;
                        bus.m_mask  <= 8'hff;
                    end
                end
                I_BUSY, D_BUSY: begin
                    cnt <= cnt + 1'b1;
                    // m_valid takes priority over an expiring counter in the same cycle.
                    if (bus.m_valid || cnt_last) begin
                        state           <= DONE;
                        bus.m_re        <= 1'b0;
                        bus.m_we        <= 1'b0;
                        bus.timeout_err <= ~bus.m_valid;
                        if (state == I_BUSY) begin
                            bus.i_valid <= 1'b1;
                            bus.i_rdata <= bus.m_valid ? bus.m_rdata : '0;
                        end else begin
                            bus.d_valid <= 1'b1;
                            bus.d_rdata <= bus.m_valid ? bus.m_rdata : '0;
                        end
                    end
                end
                default: begin
                    state           <= IDLE;
                    bus.i_valid     <= 1'b0;
                    bus.i_rdata     <= '0;
                    bus.d_valid     <= 1'b0;
                    bus.d_rdata     <= '0;
                    bus.owner       <= 2'b00;
                    bus.timeout_err <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22051013_axi_arbiter.sv
// Directed bench for the icache/dcache AXI arbiter, built with TIMEOUT=4.
module tb_ysyx_22051013_axi_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    ysyx_22051013_axi_arbiter_if bus();

    ysyx_22051013_axi_arbiter #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_re    = 1'b0;
        bus.i_addr  = '0;
        bus.d_re    = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_mask  = '0;
        bus.m_valid = 1'b0;
        bus.m_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " m_re"},    {63'd0, bus.m_re}, 64'd0);
        check({tag, " m_we"},    {63'd0, bus.m_we}, 64'd0);
        check({tag, " m_addr"},  bus.m_addr, 64'd0);
        check({tag, " m_mask"},  {56'd0, bus.m_mask}, 64'd0);
        check({tag, " i_valid"}, {63'd0, bus.i_valid}, 64'd0);
        check({tag, " d_valid"}, {63'd0, bus.d_valid}, 64'd0);
        check({tag, " d_rdata"}, bus.d_rdata, 64'd0);
        check({tag, " owner"},   {62'd0, bus.owner}, 64'd0);
        check({tag, " tmo"},     {63'd0, bus.timeout_err}, 64'd0);
    endtask

    initial begin
        idle_inputs();
        #1;
        check_all_zero("rst");
        step();
        rst_n = 1'b1;

        // single icache read
        bus.i_re   = 1'b1;
        bus.i_addr = 64'h8000_0000;
        step();
        check("i m_re",    {63'd0, bus.m_re}, 64'd1);
        check("i m_we",    {63'd0, bus.m_we}, 64'd0);
        check("i m_addr",  bus.m_addr, 64'h8000_0000);
        check("i m_mask",  {56'd0, bus.m_mask}, 64'hff);
        check("i m_wdata", bus.m_wdata, 64'd0);
        check("i owner",   {62'd0, bus.owner}, 64'd1);
        check("i rdata0",  bus.i_rdata, 64'd0);
        step();
        step();
        bus.m_valid = 1'b1;
        bus.m_rdata = 64'h1234;
        step();
        check("i valid",   {63'd0, bus.i_valid}, 64'd1);
        check("i rdata",   bus.i_rdata, 64'h1234);
        check("i m_re off", {63'd0, bus.m_re}, 64'd0);
        check("i owner d", {62'd0, bus.owner}, 64'd1);
        check("i d_valid", {63'd0, bus.d_valid}, 64'd0);
        bus.m_valid = 1'b0;
        bus.i_re    = 1'b0;
        step();
        check("i valid end", {63'd0, bus.i_valid}, 64'd0);
        check("i rdata end", bus.i_rdata, 64'd0);
        check("i owner end", {62'd0, bus.owner}, 64'd0);

        // tie alternation starting with D after reset
        do_reset();
        bus.i_re   = 1'b1;
        bus.i_addr = 64'h1000;
        bus.d_re   = 1'b1;
        bus.d_addr = 64'h2000;
        for (int k = 0; k < 4; k++) begin
            logic d_turn;
            d_turn = (k % 2 == 0);
            step();
            check($sformatf("rr%0d owner", k), {62'd0, bus.owner}, d_turn ? 64'd2 : 64'd1);
            check($sformatf("rr%0d addr", k), bus.m_addr, d_turn ? 64'h2000 : 64'h1000);
            check($sformatf("rr%0d m_re", k), {63'd0, bus.m_re}, 64'd1);
            bus.m_valid = 1'b1;
            bus.m_rdata = 64'h100 + 64'(k);
            step();
            bus.m_valid = 1'b0;
            check($sformatf("rr%0d d_valid", k), {63'd0, bus.d_valid}, d_turn ? 64'd1 : 64'd0);
            check($sformatf("rr%0d i_valid", k), {63'd0, bus.i_valid}, d_turn ? 64'd0 : 64'd1);
            check($sformatf("rr%0d rdata", k), d_turn ? bus.d_rdata : bus.i_rdata, 64'h100 + 64'(k));
            step();
        end
        idle_inputs();
        step();

        // write wins over read on the dcache side
        bus.d_we    = 1'b1;
        bus.d_re    = 1'b1;
        bus.d_addr  = 64'ha000_03f8;
        bus.d_mask  = 8'h0f;
        bus.d_wdata = 64'h55;
        step();
        check("w m_we",    {63'd0, bus.m_we}, 64'd1);
        check("w m_re",    {63'd0, bus.m_re}, 64'd0);
        check("w m_addr",  bus.m_addr, 64'ha000_03f8);
        check("w m_mask",  {56'd0, bus.m_mask}, 64'h0f);
        check("w m_wdata", bus.m_wdata, 64'h55);
        check("w owner",   {62'd0, bus.owner}, 64'd2);
        bus.m_valid = 1'b1;
        step();
        check("w d_valid", {63'd0, bus.d_valid}, 64'd1);
        check("w m_we off", {63'd0, bus.m_we}, 64'd0);
        idle_inputs();
        step();

        // timeout after 4 busy cycles
        bus.d_re    = 1'b1;
        bus.d_addr  = 64'h3000;
        bus.m_rdata = 64'hdead;
        step();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("to%0d owner", k), {62'd0, bus.owner}, 64'd2);
            check($sformatf("to%0d d_valid", k), {63'd0, bus.d_valid}, 64'd0);
            check($sformatf("to%0d tmo", k), {63'd0, bus.timeout_err}, 64'd0);
            step();
        end
        check("to d_valid", {63'd0, bus.d_valid}, 64'd1);
        check("to d_rdata", bus.d_rdata, 64'd0);
        check("to tmo",     {63'd0, bus.timeout_err}, 64'd1);
        check("to m_re",    {63'd0, bus.m_re}, 64'd0);
        bus.d_re = 1'b0;
        step();
        check("to tmo end", {63'd0, bus.timeout_err}, 64'd0);
        check("to dv end",  {63'd0, bus.d_valid}, 64'd0);

        // m_valid on the last allowed busy cycle completes normally
        bus.d_re = 1'b1;
        step();
        step();
        step();
        step();
        bus.m_valid = 1'b1;
        bus.m_rdata = 64'hbeef;
        step();
        check("edge d_valid", {63'd0, bus.d_valid}, 64'd1);
        check("edge rdata",   bus.d_rdata, 64'hbeef);
        check("edge tmo",     {63'd0, bus.timeout_err}, 64'd0);
        idle_inputs();
        step();

        // reset in the middle of a dcache transaction
        bus.d_re   = 1'b1;
        bus.d_addr = 64'h4000;
        step();
        check("ar owner", {62'd0, bus.owner}, 64'd2);
        rst_n = 1'b0;
        #1;
        check_all_zero("ar async");
        bus.d_re = 1'b0;
        step();
        rst_n = 1'b1;
        bus.m_valid = 1'b1;
        bus.m_rdata = 64'h77;
        step();
        bus.m_valid = 1'b0;
        check_all_zero("ar post");

        // held fields during busy, stray m_valid in IDLE
        bus.d_re   = 1'b1;
        bus.d_addr = 64'h5000;
        step();
        bus.d_addr = 64'h6000;
        bus.d_re   = 1'b0;
        step();
        check("hold addr", bus.m_addr, 64'h5000);
        check("hold m_re", {63'd0, bus.m_re}, 64'd1);
        bus.m_valid = 1'b1;
        step();
        bus.m_valid = 1'b0;
        check("hold d_valid", {63'd0, bus.d_valid}, 64'd1);
        step();
        bus.m_valid = 1'b1;
        bus.m_rdata = 64'h99;
        step();
        bus.m_valid = 1'b0;
        check("stray d_valid", {63'd0, bus.d_valid}, 64'd0);
        check("stray i_valid", {63'd0, bus.i_valid}, 64'd0);
        check("stray owner",   {62'd0, bus.owner}, 64'd0);
        check("stray m_addr",  bus.m_addr, 64'h5000);
        check("stray m_re",    {63'd0, bus.m_re}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_22051013_axi_arbiter.md
YSYX_22051013_AXI_ARBITER -- requirements
Module: ysyx_22051013_axi_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum BUSY cycles waited for m_valid before forced completion.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 i_re  input  1  icache read request.
REQ-005 i_addr  input  64  icache request address.
REQ-006 i_valid  output  1  icache completion pulse.
REQ-007 i_rdata  output  64  icache read data; valid only with i_valid.
REQ-008 d_re / d_we  input  1 each  dcache-side read / write request (from the dcache/device select path).
REQ-009 d_addr  input  64  dcache-side address.
REQ-010 d_wdata  input  64  dcache-side write data.
REQ-011 d_mask  input  8  dcache-side byte mask.
REQ-012 d_valid  output  1  dcache-side completion pulse.
REQ-013 d_rdata  output  64  dcache-side read data; valid only with d_valid.
REQ-014 m_re / m_we  output  1 each  downstream AXI read / write request.
REQ-015 m_addr, m_wdata  output  64 each  downstream address / write data.
REQ-016 m_mask  output  8  downstream byte mask.
REQ-017 m_valid  input  1  downstream completion pulse.
REQ-018 m_rdata  input  64  downstream read data, qualified by m_valid.
REQ-019 owner  output  2  current owner: 00 none, 01 icache, 10 dcache-side.
REQ-020 timeout_err  output  1  one-cycle pulse on forced completion.

Function
REQ-021 FSM states IDLE, I_BUSY, D_BUSY, DONE; exactly one active.
REQ-022 IDLE: request I = i_re; request D = d_re|d_we; no request -> stay IDLE.
REQ-023 Single request -> grant that requester; both -> grant the one NOT recorded in last_grant; last_grant updates on every grant.
REQ-024 On grant edge, latch addr/wdata/mask and type into output registers; m_re/m_we go high the cycle after the request is sampled (latency 1).
REQ-025 I grant: m_re=1, m_we=0, m_mask=8'hff, m_wdata=0.
REQ-026 D grant with d_we=1: m_we=1, m_re=0 (write wins if d_re and d_we both high); else m_re=1.
REQ-027 m_re/m_we/m_addr/m_wdata/m_mask held constant throughout BUSY, regardless of requester input changes.
REQ-028 In BUSY, m_valid=1 -> latch m_rdata, drop m_re/m_we on that edge, go DONE.
REQ-029 DONE lasts exactly one cycle: owner's valid=1 with latched rdata; other valid=0; next state IDLE.
REQ-030 Requests present during BUSY or DONE are not sampled; requester deasserts in the cycle of its valid pulse, else a new transaction starts from IDLE.
REQ-031 m_valid outside BUSY is ignored.
REQ-032 Timeout counter (8 bits min, width clog2(TIMEOUT+1)) clears on BUSY entry, increments each BUSY cycle without m_valid; at count==TIMEOUT -> DONE with rdata=0, timeout_err=1 during the DONE cycle, owner's valid still pulsed.
REQ-033 m_valid in the same cycle as count==TIMEOUT -> normal completion, no timeout_err.
REQ-034 owner reflects state: 01 in I_BUSY/I-owned DONE, 10 in D_BUSY/D-owned DONE, 00 in IDLE.
REQ-035 i_rdata/d_rdata are 0 whenever the matching valid is 0.

Reset
REQ-036 rst_n low -> immediately: state IDLE, all outputs 0, counter 0, last_grant=I (so D wins first tie).
REQ-037 Reset mid-transaction aborts it with no valid pulse; first request after release treated as fresh.

Verification
REQ-038 Reset release, i_re=1, i_addr=0x8000_0000 -> m_re=1 next cycle, m_addr=0x8000_0000, m_mask=ff; m_valid with m_rdata=0x1234 after 3 cycles -> i_valid=1, i_rdata=0x1234 one cycle later, owner 01->00.
REQ-039 i_re and d_re both held from IDLE after reset -> D granted first, then I; alternation continues for 4 transactions.
REQ-040 d_we=1, d_re=1, d_addr=0xa000_03f8, d_mask=0x0f, d_wdata=0x55 -> m_we=1, m_re=0, fields exact; d_valid after m_valid.
REQ-041 TIMEOUT=4, d_re with m_valid never asserted -> D_BUSY 4 cycles, then d_valid=1, d_rdata=0, timeout_err=1 for one cycle.
REQ-042 rst_n low during D_BUSY, then m_valid pulse after release -> no d_valid, outputs 0, state IDLE.
REQ-043 Change d_addr during D_BUSY and pulse m_valid in IDLE -> m_addr unchanged, stray m_valid produces no valid.
